// File: rtl/load_pipelined_if.sv
// Handshake bundle for load_pipelined: circuit address/data channels, memory channels
// and the outstanding-load count. The slave modport is the load port's view.
interface load_pipelined_if #(
    parameter int DATA_TYPE = 32,
    parameter int ADDR_TYPE = 32,
    parameter int NUM_SLOTS = 4
);
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);

    logic [ADDR_TYPE-1:0] addrIn;
    logic                 addrIn_valid;
    logic                 addrIn_ready;
    logic [ADDR_TYPE-1:0] addrOut;
    logic                 addrOut_valid;
    logic                 addrOut_ready;
    logic [DATA_TYPE-1:0] dataFromMem;
    logic                 dataFromMem_valid;
    logic                 dataFromMem_ready;
    logic [DATA_TYPE-1:0] dataOut;
    logic                 dataOut_valid;
    logic                 dataOut_ready;
    logic [CNT_W-1:0]     outstanding;

    modport slave (
        input  addrIn, addrIn_valid, addrOut_ready,
        input  dataFromMem, dataFromMem_valid, dataOut_ready,
        output addrIn_ready, addrOut, addrOut_valid,
        output dataFromMem_ready, dataOut, dataOut_valid, outstanding
    );

    modport master (
        output addrIn, addrIn_valid, addrOut_ready,
        output dataFromMem, dataFromMem_valid, dataOut_ready,
        input  addrIn_ready, addrOut, addrOut_valid,
        input  dataFromMem_ready, dataOut, dataOut_valid, outstanding
    );
endinterface

// File: rtl/load_pipelined.sv
// Pipelined load port: one-entry registered address stage, credit counter bounding
// outstanding loads, and a NUM_SLOTS-deep in-order return data FIFO.
module load_pipelined #(
    parameter int DATA_TYPE = 32,
    parameter int ADDR_TYPE = 32,
    parameter int NUM_SLOTS = 4
) (
    input logic            clk,
    input logic            rst,
    load_pipelined_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);
    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_SLOTS);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_SLOTS - 1);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_TYPE-1:0] addr_q, addr_d;
    logic                 addr_v_q, addr_v_d;
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     occ_q, occ_d;
    logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];

    logic full, empty, addr_rdy, accept, deliver, wr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        full     = (occ_q == CNT_MAX);
        empty    = (occ_q == '0);
        // Credits are counted only from registered state, so a slot freed by a
        // delivery becomes usable on the following cycle.
        addr_rdy = !rst && (cnt_q < CNT_MAX) && (!addr_v_q || bus.addrOut_ready);
        accept   = bus.addrIn_valid && addr_rdy;
        deliver  = !empty && bus.dataOut_ready;
        wr       = bus.dataFromMem_valid && !full;

        cnt_d = cnt_q;
        if (accept && !deliver) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!accept && deliver) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        addr_d   = addr_q;
        addr_v_d = addr_v_q;
        if (accept) begin
            addr_d   = bus.addrIn;
            addr_v_d = 1'b1;
        end else if (bus.addrOut_ready) begin
            addr_v_d = 1'b0;
        end

        head_d = deliver ? ptr_inc(head_q) : head_q;
        tail_d = wr ? ptr_inc(tail_q) : tail_q;
        occ_d  = occ_q;
        if (wr && !deliver) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (!wr && deliver) begin
            occ_d = occ_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            addr_q   <= '0;
            addr_v_q <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
            occ_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            addr_v_q <= addr_v_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[tail_q] <= bus.dataFromMem;
        end
    end

    assign bus.addrIn_ready      = addr_rdy;
    assign bus.addrOut           = addr_q;
    assign bus.addrOut_valid     = addr_v_q;
    assign bus.dataFromMem_ready = !full;
    assign bus.dataOut           = mem_q[head_q];
    assign bus.dataOut_valid     = !empty;
    assign bus.outstanding       = cnt_q;
endmodule

// File: tb/tb_load_pipelined.sv
// Bench for load_pipelined: three instances (NUM_SLOTS 4, 3, 1) checked every cycle
// against a queue-based reference model, plus a directed vector table on the 4-slot one.
module tb_load_pipelined;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        av [3];
    logic [31:0] ain [3];
    logic        aor [3];
    logic        dv [3];
    logic [31:0] din [3];
    logic        dor [3];
    logic        air [3], aov [3], dov [3], dfr [3];
    logic [31:0] ao [3], dout [3];
    logic [7:0]  outs [3];

    load_pipelined_if #(.DATA_TYPE(32), .ADDR_TYPE(32), .NUM_SLOTS(4)) if0 ();
    load_pipelined_if #(.DATA_TYPE(32), .ADDR_TYPE(32), .NUM_SLOTS(3)) if1 ();
    load_pipelined_if #(.DATA_TYPE(32), .ADDR_TYPE(32), .NUM_SLOTS(1)) if2 ();

    load_pipelined #(.DATA_TYPE(32), .ADDR_TYPE(32), .NUM_SLOTS(4)) u0 (.clk(clk), .rst(rst), .bus(if0));
    load_pipelined #(.DATA_TYPE(32), .ADDR_TYPE(32), .NUM_SLOTS(3)) u1 (.clk(clk), .rst(rst), .bus(if1));
    load_pipelined #(.DATA_TYPE(32), .ADDR_TYPE(32), .NUM_SLOTS(1)) u2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.addrIn = ain[0];  assign if0.addrIn_valid = av[0];  assign if0.addrOut_ready = aor[0];
    assign if0.dataFromMem = din[0];  assign if0.dataFromMem_valid = dv[0];  assign if0.dataOut_ready = dor[0];
    assign if1.addrIn = ain[1];  assign if1.addrIn_valid = av[1];  assign if1.addrOut_ready = aor[1];
    assign if1.dataFromMem = din[1];  assign if1.dataFromMem_valid = dv[1];  assign if1.dataOut_ready = dor[1];
    assign if2.addrIn = ain[2];  assign if2.addrIn_valid = av[2];  assign if2.addrOut_ready = aor[2];
    assign if2.dataFromMem = din[2];  assign if2.dataFromMem_valid = dv[2];  assign if2.dataOut_ready = dor[2];

    assign air[0] = if0.addrIn_ready;  assign aov[0] = if0.addrOut_valid;  assign ao[0] = if0.addrOut;
    assign dov[0] = if0.dataOut_valid;  assign dout[0] = if0.dataOut;  assign dfr[0] = if0.dataFromMem_ready;
    assign outs[0] = 8'(if0.outstanding);
    assign air[1] = if1.addrIn_ready;  assign aov[1] = if1.addrOut_valid;  assign ao[1] = if1.addrOut;
    assign dov[1] = if1.dataOut_valid;  assign dout[1] = if1.dataOut;  assign dfr[1] = if1.dataFromMem_ready;
    assign outs[1] = 8'(if1.outstanding);
    assign air[2] = if2.addrIn_ready;  assign aov[2] = if2.addrOut_valid;  assign ao[2] = if2.addrOut;
    assign dov[2] = if2.dataOut_valid;  assign dout[2] = if2.dataOut;  assign dfr[2] = if2.dataFromMem_ready;
    assign outs[2] = 8'(if2.outstanding);

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: loads in the address stage, loads sent to memory awaiting data,
    // and returned data waiting for the consumer.
    int          m_cnt [3];
    logic [31:0] m_pipe [3][$];
    logic [31:0] m_pend [3][$];
    logic [31:0] m_fifo [3][$];

    function automatic int ns_of(input int i);
        case (i)
            0:       return 4;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %h expected %h", nm, i, act, exp);
        end
    endtask

    function automatic logic exp_air(input int i);
        return !rst && (m_cnt[i] < ns_of(i)) && (m_pipe[i].size() == 0 || aor[i]);
    endfunction

    task automatic model_check(input int i);
        chk("addrIn_ready", i, 32'(air[i]), 32'(exp_air(i)));
        chk("addrOut_valid", i, 32'(aov[i]), 32'(m_pipe[i].size() != 0));
        if (m_pipe[i].size() != 0) chk("addrOut", i, ao[i], m_pipe[i][0]);
        chk("dataOut_valid", i, 32'(dov[i]), 32'(m_fifo[i].size() != 0));
        if (m_fifo[i].size() != 0) chk("dataOut", i, dout[i], m_fifo[i][0]);
        chk("dataFromMem_ready", i, 32'(dfr[i]), 32'(m_fifo[i].size() < ns_of(i)));
        chk("outstanding", i, 32'(outs[i]), 32'(m_cnt[i]));
    endtask

    task automatic model_update(input int i);
        logic acc, fire, wr, del;
        if (rst) begin
            m_pipe[i].delete(); m_pend[i].delete(); m_fifo[i].delete();
            m_cnt[i] = 0;
            return;
        end
        acc  = av[i] && exp_air(i);
        fire = (m_pipe[i].size() != 0) && aor[i];
        wr   = dv[i] && (m_fifo[i].size() < ns_of(i));
        del  = (m_fifo[i].size() != 0) && dor[i];
        if (del) void'(m_fifo[i].pop_front());
        if (wr) begin
            m_fifo[i].push_back(din[i]);
            if (m_pend[i].size() != 0) void'(m_pend[i].pop_front());
        end
        if (fire) m_pend[i].push_back(m_pipe[i].pop_front());
        if (acc) m_pipe[i].push_back(ain[i]);
        m_cnt[i] = m_cnt[i] + int'(acc) - int'(del);
    endtask

    // Called #1 after a falling edge: model check, model step, advance one cycle.
    task automatic finish_cycle();
        for (int i = 0; i < 3; i++) model_check(i);
        for (int i = 0; i < 3; i++) model_update(i);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic adv();
        #1;
        finish_cycle();
    endtask

    task automatic clr_inputs();
        for (int i = 0; i < 3; i++) begin
            av[i] = 0; ain[i] = '0; aor[i] = 0; dv[i] = 0; din[i] = '0; dor[i] = 0;
        end
    endtask

    typedef struct {
        logic rst, av; logic [31:0] a; logic aor, dv; logic [31:0] d; logic dor;
        logic e_air, e_aov; logic [31:0] e_ao; logic e_dov; logic [31:0] e_dq; logic e_dfr; logic [7:0] e_out;
    } vec_t;
    vec_t tbl [$];

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] a, input logic ar,
                                input logic dvv, input logic [31:0] d, input logic dr,
                                input logic e_air, input logic e_aov, input logic [31:0] e_ao,
                                input logic e_dov, input logic [31:0] e_dq, input logic e_dfr,
                                input logic [7:0] e_out);
        vec_t x;
        x.rst = r; x.av = v; x.a = a; x.aor = ar; x.dv = dvv; x.d = d; x.dor = dr;
        x.e_air = e_air; x.e_aov = e_aov; x.e_ao = e_ao; x.e_dov = e_dov; x.e_dq = e_dq;
        x.e_dfr = e_dfr; x.e_out = e_out;
        return x;
    endfunction

    task automatic directed(input int i);
        int ns;
        ns = ns_of(i);
        clr_inputs();
        av[i] = 1; ain[i] = 32'h10; aor[i] = 1; dor[i] = 1;
        adv();
        av[i] = 0;
        adv();
        adv();
        dv[i] = 1; din[i] = 32'hABCD;
        adv();
        dv[i] = 0;
        #1;
        chk("single_dataOut", i, dout[i], 32'hABCD);
        finish_cycle();
        adv();
        for (int k = 0; k <= ns; k++) begin
            av[i] = 1; ain[i] = 32'(k);
            adv();
        end
        dv[i] = 1; din[i] = 32'hC0DE;
        #1;
        chk("stall_outstanding", i, 32'(outs[i]), 32'(ns));
        chk("stall_addrIn_ready", i, 32'(air[i]), 32'd0);
        finish_cycle();
        dv[i] = 0;
        adv();
        #1;
        chk("freed_slot_ready", i, 32'(air[i]), 32'd1);
        finish_cycle();
        av[i] = 0;
        adv();
    endtask

    initial begin
        clr_inputs();
        rst = 1;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        @(posedge clk);
        @(negedge clk);

        //         rst av a        aor dv d          dor | air aov ao      dov do         dfr out
        tbl.push_back(mk(1, 1, 'h55,   1, 0, 0,        0,   0, 0, 0,     0, 0,        1, 0));
        tbl.push_back(mk(1, 1, 'h55,   1, 0, 0,        0,   0, 0, 0,     0, 0,        1, 0));
        tbl.push_back(mk(0, 1, 'h10,   1, 0, 0,        1,   1, 0, 0,     0, 0,        1, 0));
        tbl.push_back(mk(0, 0, 0,      1, 0, 0,        1,   1, 1, 'h10,  0, 0,        1, 1));
        tbl.push_back(mk(0, 0, 0,      1, 0, 0,        1,   1, 0, 0,     0, 0,        1, 1));
        tbl.push_back(mk(0, 0, 0,      1, 1, 'hABCD,   1,   1, 0, 0,     0, 0,        1, 1));
        tbl.push_back(mk(0, 0, 0,      1, 0, 0,        1,   1, 0, 0,     1, 'hABCD,   1, 1));
        tbl.push_back(mk(0, 0, 0,      1, 0, 0,        1,   1, 0, 0,     0, 0,        1, 0));
        tbl.push_back(mk(0, 1, 0,      1, 0, 0,        1,   1, 0, 0,     0, 0,        1, 0));
        tbl.push_back(mk(0, 1, 1,      1, 0, 0,        1,   1, 1, 0,     0, 0,        1, 1));
        tbl.push_back(mk(0, 1, 2,      1, 0, 0,        1,   1, 1, 1,     0, 0,        1, 2));
        tbl.push_back(mk(0, 1, 3,      1, 0, 0,        1,   1, 1, 2,     0, 0,        1, 3));
        tbl.push_back(mk(0, 1, 4,      1, 0, 0,        1,   0, 1, 3,     0, 0,        1, 4));
        tbl.push_back(mk(0, 1, 4,      1, 1, 'hD0,     1,   0, 0, 0,     0, 0,        1, 4));
        tbl.push_back(mk(0, 1, 4,      1, 0, 0,        1,   0, 0, 0,     1, 'hD0,     1, 4));
        tbl.push_back(mk(0, 1, 4,      1, 0, 0,        1,   1, 0, 0,     0, 0,        1, 3));
        tbl.push_back(mk(0, 0, 0,      1, 0, 0,        0,   0, 1, 4,     0, 0,        1, 4));
        tbl.push_back(mk(0, 0, 0,      1, 1, 'hE0,     0,   0, 0, 0,     0, 0,        1, 4));
        tbl.push_back(mk(0, 0, 0,      1, 1, 'hE1,     0,   0, 0, 0,     1, 'hE0,     1, 4));
        tbl.push_back(mk(0, 0, 0,      1, 1, 'hE2,     0,   0, 0, 0,     1, 'hE0,     1, 4));
        tbl.push_back(mk(0, 0, 0,      1, 1, 'hE3,     0,   0, 0, 0,     1, 'hE0,     1, 4));
        tbl.push_back(mk(0, 0, 0,      1, 0, 0,        0,   0, 0, 0,     1, 'hE0,     0, 4));
        tbl.push_back(mk(0, 0, 0,      1, 0, 0,        1,   0, 0, 0,     1, 'hE0,     0, 4));
        tbl.push_back(mk(0, 0, 0,      1, 0, 0,        1,   1, 0, 0,     1, 'hE1,     1, 3));
        tbl.push_back(mk(0, 1, 'h77,   0, 0, 0,        1,   1, 0, 0,     1, 'hE2,     1, 2));
        tbl.push_back(mk(0, 1, 'h88,   0, 0, 0,        0,   0, 1, 'h77,  1, 'hE3,     1, 2));
        tbl.push_back(mk(0, 1, 'h88,   0, 0, 0,        0,   0, 1, 'h77,  1, 'hE3,     1, 2));
        tbl.push_back(mk(0, 0, 0,      1, 0, 0,        1,   1, 1, 'h77,  1, 'hE3,     1, 2));
        tbl.push_back(mk(0, 1, 'h90,   1, 0, 0,        0,   1, 0, 0,     0, 0,        1, 1));
        tbl.push_back(mk(0, 1, 'h91,   1, 1, 'hF0,     0,   1, 1, 'h90,  0, 0,        1, 2));
        tbl.push_back(mk(0, 0, 0,      1, 1, 'hF1,     0,   1, 1, 'h91,  1, 'hF0,     1, 3));
        tbl.push_back(mk(1, 0, 0,      1, 0, 0,        0,   0, 0, 0,     1, 'hF0,     1, 3));
        tbl.push_back(mk(0, 1, 'h20,   1, 0, 0,        1,   1, 0, 0,     0, 0,        1, 0));
        tbl.push_back(mk(0, 0, 0,      1, 0, 0,        1,   1, 1, 'h20,  0, 0,        1, 1));
        tbl.push_back(mk(0, 0, 0,      1, 1, 'h1234,   1,   1, 0, 0,     0, 0,        1, 1));
        tbl.push_back(mk(0, 0, 0,      1, 0, 0,        1,   1, 0, 0,     1, 'h1234,   1, 1));
        tbl.push_back(mk(0, 0, 0,      1, 0, 0,        1,   1, 0, 0,     0, 0,        1, 0));

        foreach (tbl[r]) begin
            clr_inputs();
            rst = tbl[r].rst;
            av[0] = tbl[r].av; ain[0] = tbl[r].a; aor[0] = tbl[r].aor;
            dv[0] = tbl[r].dv; din[0] = tbl[r].d; dor[0] = tbl[r].dor;
            #1;
            chk($sformatf("row%0d.addrIn_ready", r), 0, 32'(air[0]), 32'(tbl[r].e_air));
            chk($sformatf("row%0d.addrOut_valid", r), 0, 32'(aov[0]), 32'(tbl[r].e_aov));
            if (tbl[r].e_aov) chk($sformatf("row%0d.addrOut", r), 0, ao[0], tbl[r].e_ao);
            chk($sformatf("row%0d.dataOut_valid", r), 0, 32'(dov[0]), 32'(tbl[r].e_dov));
            if (tbl[r].e_dov) chk($sformatf("row%0d.dataOut", r), 0, dout[0], tbl[r].e_dq);
            chk($sformatf("row%0d.dataFromMem_ready", r), 0, 32'(dfr[0]), 32'(tbl[r].e_dfr));
            chk($sformatf("row%0d.outstanding", r), 0, 32'(outs[0]), 32'(tbl[r].e_out));
            finish_cycle();
        end

        rst = 0;
        directed(1);
        directed(2);

        clr_inputs();
        rst = 1;
        adv();
        adv();
        rst = 0;

        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < 3; i++) begin
                av[i]  = ($urandom_range(0, 9) < 7);
                ain[i] = $urandom;
                aor[i] = ($urandom_range(0, 3) != 0);
                dor[i] = ($urandom_range(0, 9) < 6);
                dv[i]  = (m_pend[i].size() != 0) && ($urandom_range(0, 9) < 7);
                din[i] = (m_pend[i].size() != 0) ? (m_pend[i][0] ^ 32'h5A5A_F00F) : $urandom;
            end
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/load_pipelined.md
Name: load_pipelined

Overview:
- Next-generation load port for the handshake library.
- Decouples the circuit-side address/data channels from the memory interface.
- Allows up to NUM_SLOTS loads to be outstanding at once; data returns in order.
- Tracks outstanding loads with credits and buffers returned data in a NUM_SLOTS-deep FIFO, so memory data is never refused.
- Sits between a circuit address producer/data consumer and an LSQ or memory controller port.

Parameters:
DATA_TYPE, 32, width of load data in bits (>=1)
ADDR_TYPE, 32, width of load address in bits (>=1)
NUM_SLOTS, 4, max outstanding loads and data FIFO depth (>=1; any integer, not only powers of two)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
addrIn  input  ADDR_TYPE  load address from circuit
addrIn_valid  input  1  address valid
addrIn_ready  output  1  address accepted when high with valid
addrOut  output  ADDR_TYPE  address to memory interface (registered)
addrOut_valid  output  1  address to memory valid
addrOut_ready  input  1  memory accepts address
dataFromMem  input  DATA_TYPE  returned data from memory, in request order
dataFromMem_valid  input  1  returned data valid
dataFromMem_ready  output  1  FIFO can accept returned data
dataOut  output  DATA_TYPE  load result to circuit
dataOut_valid  output  1  load result valid
dataOut_ready  input  1  circuit consumes result
outstanding  output  clog2(NUM_SLOTS+1)  loads accepted but not yet delivered on dataOut

Behaviour:
- Reset (rst=1 at posedge) clears all state.
  - addrOut_valid=0, dataOut_valid=0, outstanding=0, FIFO empty.
  - dataFromMem_ready=1 after reset.
  - addrOut and dataOut data values are don't-care when their valid is 0.
  - Reset mid-operation discards all in-flight addresses, buffered data and credits.
- Credit counter cnt is 0..NUM_SLOTS and drives the outstanding port directly.
  - accept = addrIn_valid & addrIn_ready.
  - deliver = dataOut_valid & dataOut_ready.
  - cnt += accept, cnt -= deliver; both in the same cycle leaves cnt unchanged.
- Address stage is a one-entry register (addr_q, addr_v_q).
  - addrIn_ready = (cnt < NUM_SLOTS) & (!addr_v_q | addrOut_ready).
  - No combinational path from dataOut_ready to addrIn_ready. A slot freed by deliver is usable from the next cycle.
  - On accept: addr_q <= addrIn, addr_v_q <= 1. Else if addrOut_ready: addr_v_q <= 0.
  - addrOut = addr_q, addrOut_valid = addr_v_q.
  - Latency: address accepted in cycle t appears on addrOut in cycle t+1.
  - Full throughput of 1 address/cycle while credits are available and addrOut_ready=1.
- Data FIFO is a circular buffer of NUM_SLOTS entries with head/tail pointers and an occupancy count.
  - Pointers wrap from NUM_SLOTS-1 to 0.
  - dataFromMem_ready = !full.
  - Write on dataFromMem_valid & dataFromMem_ready.
  - dataOut = entry[head], dataOut_valid = !empty.
  - No bypass: data written in cycle t is visible on dataOut at t+1.
  - Simultaneous write and read when full: write is not accepted (ready=0 that cycle). When neither full nor empty: both proceed and occupancy is unchanged.
  - Because of credit reservation, a compliant memory never sees ready=0. This is a structural guarantee; returned data beyond cnt is a protocol violation with undefined result.
- Order: dataOut order equals addrIn acceptance order; memory must also return in order.
- dataOut and addrOut hold stable while valid and not ready (standard valid/ready persistence).

Test Plan:
- Reset: assert rst 2 cycles with addrIn_valid=1 -> addrIn_ready stays low through the reset cycles; addrOut_valid=0, dataOut_valid=0, outstanding=0, dataFromMem_ready=1.
- Single load: addrIn=0x10 at t, addrOut_ready=1 -> addrOut=0x10 valid at t+1. Memory returns 0xABCD at t+3 -> dataOut=0xABCD valid at t+4; outstanding goes 1 then 0 after deliver.
- Credit stall (NUM_SLOTS=4): issue addresses 0..4 back-to-back with no data returned -> 4 accepted; addrIn_ready=0 for the 5th, outstanding=4. Return one datum and consume it -> the 5th is accepted the following cycle.
- Back-pressure: dataOut_ready=0, memory returns D0..D3 -> all accepted, FIFO full, dataFromMem_ready=0. Release ready -> D0..D3 delivered in order over 4 cycles, with pointer wrap exercised.
- Simultaneous: cnt=2, accept and deliver in the same cycle -> outstanding stays 2. With addrOut_ready=0 and addr_v_q=1 -> addrIn_ready=0 and addrOut held stable.
- Reset mid-operation with 3 outstanding and 2 buffered data -> next cycle everything is empty/zero; a new load then completes normally. Repeat the single-load and credit-stall cases with NUM_SLOTS=1 and NUM_SLOTS=3 (non-power-of-two wrap).
